// File: rtl/fwd_hazard_unit_pkg.sv
// Shared constants for the pipeline forwarding and hazard logic.
package hazard_pkg;

  // Default architectural register address width (32 registers).
  localparam int DEFAULT_REG_AW = 5;

  // Operand source selects driven to the EX and ID-branch operand muxes.
  localparam logic [1:0] FWD_REG   = 2'b00;
  localparam logic [1:0] FWD_EXMEM = 2'b01;
  localparam logic [1:0] FWD_MEMWB = 2'b10;

  // Width of the multi-cycle latency counter; latencies up to 15 fit.
  localparam int MC_CNT_W = 4;

endpackage

// File: rtl/fwd_hazard_unit_mc_scoreboard.sv
// Single-entry scoreboard tracking the outstanding MUL/DIV result.
module mc_scoreboard
  import hazard_pkg::*;
#(
  parameter int REG_AW = DEFAULT_REG_AW,
  parameter int MC_LAT = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              issue,
  input  logic [REG_AW-1:0] issueRd,
  output logic              mcBusy,
  output logic              mcDone,
  output logic [REG_AW-1:0] mcRd
);

  localparam logic [MC_CNT_W-1:0] LAT = MC_CNT_W'(MC_LAT);

  logic [MC_CNT_W-1:0] mcCnt;

  // Count down the outstanding op; a new issue is only taken when idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcCnt  <= '0;
      mcRd   <= '0;
      mcDone <= 1'b0;
    end else begin
      mcDone <= (mcCnt == MC_CNT_W'(1));
      if (mcCnt != '0) begin
        mcCnt <= mcCnt - 1'b1;
      end else if (issue) begin
        mcCnt <= LAT;
        mcRd  <= issueRd;
      end
    end
  end

  assign mcBusy = (mcCnt != '0);

endmodule

// File: rtl/fwd_hazard_unit.sv
// Forwarding selects, pipeline interlocks and stall statistics for the
// 5-stage RV32 pipeline.
module fwd_hazard_unit
  import hazard_pkg::*;
#(
  parameter int REG_AW = DEFAULT_REG_AW,
  parameter int MC_LAT = 4,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic              id_use_rs1,
  input  logic              id_use_rs2,
  input  logic              id_is_branch,
  input  logic              id_is_mc,
  input  logic [REG_AW-1:0] id_rd,
  input  logic              ex_valid,
  input  logic              ex_regwrite,
  input  logic              ex_memread,
  input  logic              ex_is_mc,
  input  logic [REG_AW-1:0] ex_rs1,
  input  logic [REG_AW-1:0] ex_rs2,
  input  logic [REG_AW-1:0] ex_rd,
  input  logic              mem_regwrite,
  input  logic              mem_memread,
  input  logic [REG_AW-1:0] mem_rd,
  input  logic              wb_regwrite,
  input  logic [REG_AW-1:0] wb_rd,
  input  logic              flush,
  input  logic              stat_clr,
  output logic [1:0]        fwd_a,
  output logic [1:0]        fwd_b,
  output logic [1:0]        fwd_c,
  output logic [1:0]        fwd_d,
  output logic              stall,
  output logic              bubble_ex,
  output logic              mc_busy,
  output logic              mc_done,
  output logic [REG_AW-1:0] mc_rd,
  output logic [CNT_W-1:0]  stall_count
);

  logic sMc;
  logic sLu;
  logic sBr;
  logic stallInt;
  logic mcIssue;

  // Youngest producer wins: MEM/WB only when MEM/EX does not match.
  function automatic logic [1:0] fwdSel(input logic memWe, input logic [REG_AW-1:0] memRd,
                                        input logic wbWe, input logic [REG_AW-1:0] wbRd,
                                        input logic [REG_AW-1:0] src);
    if (memWe && (memRd != '0) && (memRd == src)) return FWD_EXMEM;
    if (wbWe && (wbRd != '0) && (wbRd == src)) return FWD_MEMWB;
    return FWD_REG;
  endfunction

  // True when register r is a real source actually read by the ID instruction.
  function automatic logic readsReg(input logic [REG_AW-1:0] r,
                                    input logic [REG_AW-1:0] rs1, input logic use1,
                                    input logic [REG_AW-1:0] rs2, input logic use2);
    return (r != '0) && ((use1 && (r == rs1)) || (use2 && (r == rs2)));
  endfunction

  // Operand selects; forced to the register file while in reset.
  always_comb begin
    fwd_a = FWD_REG;
    fwd_b = FWD_REG;
    fwd_c = FWD_REG;
    fwd_d = FWD_REG;
    if (rst_n) begin
      fwd_a = fwdSel(mem_regwrite, mem_rd, wb_regwrite, wb_rd, ex_rs1);
      fwd_b = fwdSel(mem_regwrite, mem_rd, wb_regwrite, wb_rd, ex_rs2);
      fwd_c = fwdSel(mem_regwrite, mem_rd, wb_regwrite, wb_rd, id_rs1);
      fwd_d = fwdSel(mem_regwrite, mem_rd, wb_regwrite, wb_rd, id_rs2);
    end
  end

  // Interlock sources; a flushed ID instruction is dead and never stalls.
  always_comb begin
    sMc = mc_busy && (readsReg(mc_rd, id_rs1, id_use_rs1, id_rs2, id_use_rs2) ||
                      ((id_rd != '0) && (id_rd == mc_rd)) || id_is_mc);
    sLu = ex_valid && ex_memread && readsReg(ex_rd, id_rs1, id_use_rs1, id_rs2, id_use_rs2);
    sBr = id_is_branch &&
          ((ex_valid && ex_regwrite && readsReg(ex_rd, id_rs1, id_use_rs1, id_rs2, id_use_rs2)) ||
           (mem_memread && readsReg(mem_rd, id_rs1, id_use_rs1, id_rs2, id_use_rs2)));
    stallInt = rst_n && (sMc || sLu || sBr) && !flush;
  end

  assign stall     = stallInt;
  assign bubble_ex = stallInt;
  assign mcIssue   = ex_valid && ex_is_mc && ex_regwrite && (ex_rd != '0);

  mc_scoreboard #(
    .REG_AW(REG_AW),
    .MC_LAT(MC_LAT)
  ) uScoreboard (
    .clk    (clk),
    .rst_n  (rst_n),
    .issue  (mcIssue),
    .issueRd(ex_rd),
    .mcBusy (mc_busy),
    .mcDone (mc_done),
    .mcRd   (mc_rd)
  );

  // Saturating stall-cycle counter; clear takes priority over counting.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_count <= '0;
    end else if (stat_clr) begin
      stall_count <= '0;
    end else if (stallInt && (stall_count != '1)) begin
      stall_count <= stall_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Self-checking bench for fwd_hazard_unit: cycle-by-cycle model comparison
// plus directed vectors with hand-computed expectations.
module tb_fwd_hazard_unit;

  localparam int REG_AW   = 5;
  localparam int MC_LAT   = 4;
  localparam int CNT_W    = 8;
  localparam int CNT_MAX  = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [4:0] id_rs1 = '0, id_rs2 = '0, id_rd = '0;
  logic id_use_rs1 = 0, id_use_rs2 = 0, id_is_branch = 0, id_is_mc = 0;
  logic ex_valid = 0, ex_regwrite = 0, ex_memread = 0, ex_is_mc = 0;
  logic [4:0] ex_rs1 = '0, ex_rs2 = '0, ex_rd = '0;
  logic mem_regwrite = 0, mem_memread = 0;
  logic [4:0] mem_rd = '0;
  logic wb_regwrite = 0;
  logic [4:0] wb_rd = '0;
  logic flush = 0, stat_clr = 0;
  logic [1:0] fwd_a, fwd_b, fwd_c, fwd_d;
  logic stall, bubble_ex, mc_busy, mc_done;
  logic [4:0] mc_rd;
  logic [CNT_W-1:0] stall_count;

  int nChecks = 0;
  int nPass = 0;

  // Model state: edge index of the last accepted issue, its destination,
  // and the expected stall count.
  int nEdge = 0;
  int mIssue = -1;
  int mMcRd = 0;
  int mCount = 0;
  bit mStall, mIss;

  fwd_hazard_unit #(.REG_AW(REG_AW), .MC_LAT(MC_LAT), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
    .id_is_branch(id_is_branch), .id_is_mc(id_is_mc), .id_rd(id_rd),
    .ex_valid(ex_valid), .ex_regwrite(ex_regwrite), .ex_memread(ex_memread),
    .ex_is_mc(ex_is_mc), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd),
    .mem_regwrite(mem_regwrite), .mem_memread(mem_memread), .mem_rd(mem_rd),
    .wb_regwrite(wb_regwrite), .wb_rd(wb_rd), .flush(flush), .stat_clr(stat_clr),
    .fwd_a(fwd_a), .fwd_b(fwd_b), .fwd_c(fwd_c), .fwd_d(fwd_d),
    .stall(stall), .bubble_ex(bubble_ex), .mc_busy(mc_busy), .mc_done(mc_done),
    .mc_rd(mc_rd), .stall_count(stall_count)
  );

  // Free-running clock, 10 time units per period.
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input int actual, input int expected);
    nChecks++;
    if (actual == expected) nPass++;
    else $display("[TB] FAIL %s actual=%0d expected=%0d (t=%0t)", name, actual, expected, $time);
  endtask

  function automatic int expFwd(input logic [4:0] src);
    if (!rst_n) return 0;
    if (mem_regwrite && mem_rd != 0 && mem_rd == src) return 1;
    if (wb_regwrite && wb_rd != 0 && wb_rd == src) return 2;
    return 0;
  endfunction

  function automatic bit modelBusy();
    return rst_n && mIssue >= 0 && (nEdge - mIssue) < MC_LAT;
  endfunction

  function automatic bit modelDone();
    return rst_n && mIssue >= 0 && (nEdge - mIssue) == MC_LAT;
  endfunction

  function automatic bit readsReg(input logic [4:0] r);
    return r != 0 && ((id_use_rs1 && id_rs1 == r) || (id_use_rs2 && id_rs2 == r));
  endfunction

  function automatic bit expStall();
    bit mcS, luS, brS;
    if (!rst_n) return 0;
    mcS = modelBusy() && (readsReg(5'(mMcRd)) || (id_rd != 0 && int'(id_rd) == mMcRd) || id_is_mc);
    luS = ex_valid && ex_memread && readsReg(ex_rd);
    brS = id_is_branch && ((ex_valid && ex_regwrite && readsReg(ex_rd)) ||
                           (mem_memread && readsReg(mem_rd)));
    return (mcS || luS || brS) && !flush;
  endfunction

  // Advance the model on each clock edge; reset abandons everything.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mIssue = -1;
      mMcRd = 0;
      mCount = 0;
    end else begin
      mStall = expStall();
      mIss = ex_valid && ex_is_mc && ex_regwrite && ex_rd != 0 && !modelBusy();
      if (stat_clr) mCount = 0;
      else if (mStall && mCount < CNT_MAX) mCount++;
      nEdge++;
      if (mIss) begin
        mIssue = nEdge;
        mMcRd = int'(ex_rd);
      end
    end
  end

  // Compare every output against the model mid-cycle.
  always @(negedge clk) begin
    checkOutput("m_fwd_a", int'(fwd_a), expFwd(ex_rs1));
    checkOutput("m_fwd_b", int'(fwd_b), expFwd(ex_rs2));
    checkOutput("m_fwd_c", int'(fwd_c), expFwd(id_rs1));
    checkOutput("m_fwd_d", int'(fwd_d), expFwd(id_rs2));
    checkOutput("m_stall", int'(stall), int'(expStall()));
    checkOutput("m_bubble", int'(bubble_ex), int'(expStall()));
    checkOutput("m_busy", int'(mc_busy), int'(modelBusy()));
    checkOutput("m_done", int'(mc_done), int'(modelDone()));
    checkOutput("m_mcrd", int'(mc_rd), mMcRd);
    checkOutput("m_count", int'(stall_count), mCount);
  end

  // Move just past the next rising edge and return all inputs to idle.
  task automatic applyStimulus();
    @(posedge clk);
    #1;
    id_rs1 = 0; id_rs2 = 0; id_rd = 0; id_use_rs1 = 0; id_use_rs2 = 0;
    id_is_branch = 0; id_is_mc = 0;
    ex_valid = 0; ex_regwrite = 0; ex_memread = 0; ex_is_mc = 0;
    ex_rs1 = 0; ex_rs2 = 0; ex_rd = 0;
    mem_regwrite = 0; mem_memread = 0; mem_rd = 0;
    wb_regwrite = 0; wb_rd = 0; flush = 0; stat_clr = 0;
  endtask

  task automatic loadUseX7();
    ex_valid = 1; ex_memread = 1; ex_regwrite = 1; ex_rd = 7;
    id_rs2 = 7; id_use_rs2 = 1;
  endtask

  initial begin
    // Reset: outputs forced idle even with hazards present on the inputs.
    applyStimulus();
    mem_regwrite = 1; mem_rd = 5; ex_rs1 = 5;
    loadUseX7();
    @(negedge clk);
    checkOutput("rst_fwd_a", int'(fwd_a), 0);
    checkOutput("rst_stall", int'(stall), 0);
    checkOutput("rst_busy", int'(mc_busy), 0);
    checkOutput("rst_count", int'(stall_count), 0);
    applyStimulus();
    rst_n = 1;

    // Forwarding priority: MEM beats WB, WB used when MEM rd is x0.
    applyStimulus();
    mem_regwrite = 1; mem_rd = 5; wb_regwrite = 1; wb_rd = 5; ex_rs1 = 5; id_rs1 = 5;
    @(negedge clk);
    checkOutput("fwd_mem_wins", int'(fwd_a), 1);
    checkOutput("fwd_c_mem", int'(fwd_c), 1);
    applyStimulus();
    mem_regwrite = 1; mem_rd = 0; wb_regwrite = 1; wb_rd = 5; ex_rs1 = 5; ex_rs2 = 5;
    @(negedge clk);
    checkOutput("fwd_wb", int'(fwd_a), 2);
    checkOutput("fwd_b_wb", int'(fwd_b), 2);

    // Load-use: one stall cycle.
    applyStimulus();
    loadUseX7();
    @(negedge clk);
    checkOutput("lu_stall", int'(stall), 1);
    checkOutput("lu_bubble", int'(bubble_ex), 1);
    applyStimulus();
    @(negedge clk);
    checkOutput("lu_count", int'(stall_count), 1);

    // Load feeding a branch: two stall cycles, then MEM/WB forward.
    applyStimulus();
    id_is_branch = 1; id_rs1 = 9; id_use_rs1 = 1;
    ex_valid = 1; ex_memread = 1; ex_regwrite = 1; ex_rd = 9;
    @(negedge clk);
    checkOutput("br_stall1", int'(stall), 1);
    applyStimulus();
    id_is_branch = 1; id_rs1 = 9; id_use_rs1 = 1;
    mem_memread = 1; mem_regwrite = 1; mem_rd = 9;
    @(negedge clk);
    checkOutput("br_stall2", int'(stall), 1);
    applyStimulus();
    id_is_branch = 1; id_rs1 = 9; id_use_rs1 = 1;
    wb_regwrite = 1; wb_rd = 9;
    @(negedge clk);
    checkOutput("br_go", int'(stall), 0);
    checkOutput("br_fwd_c", int'(fwd_c), 2);
    checkOutput("br_count", int'(stall_count), 3);

    // MUL to x3 with a dependent instruction waiting in ID.
    applyStimulus();
    ex_valid = 1; ex_is_mc = 1; ex_regwrite = 1; ex_rd = 3;
    id_rs1 = 3; id_use_rs1 = 1;
    @(negedge clk);
    checkOutput("mc_issue_nostall", int'(stall), 0);
    for (int i = 0; i < MC_LAT; i++) begin
      applyStimulus();
      id_rs1 = 3; id_use_rs1 = 1;
      @(negedge clk);
      checkOutput("mc_busy", int'(mc_busy), 1);
      checkOutput("mc_stall", int'(stall), 1);
      checkOutput("mc_rd", int'(mc_rd), 3);
      checkOutput("mc_done_early", int'(mc_done), 0);
    end
    applyStimulus();
    id_rs1 = 3; id_use_rs1 = 1;
    @(negedge clk);
    checkOutput("mc_free", int'(mc_busy), 0);
    checkOutput("mc_release", int'(stall), 0);
    checkOutput("mc_done", int'(mc_done), 1);
    applyStimulus();
    @(negedge clk);
    checkOutput("mc_done_once", int'(mc_done), 0);
    checkOutput("mc_count", int'(stall_count), 7);

    // Flush overrides a load-use stall; stat_clr overrides counting.
    applyStimulus();
    loadUseX7(); flush = 1;
    @(negedge clk);
    checkOutput("flush_stall", int'(stall), 0);
    applyStimulus();
    @(negedge clk);
    checkOutput("flush_count", int'(stall_count), 7);
    applyStimulus();
    loadUseX7(); stat_clr = 1;
    @(negedge clk);
    checkOutput("clr_stall", int'(stall), 1);
    applyStimulus();
    @(negedge clk);
    checkOutput("clr_count", int'(stall_count), 0);

    // WAW and second MUL stall, then reset with two cycles left.
    applyStimulus();
    ex_valid = 1; ex_is_mc = 1; ex_regwrite = 1; ex_rd = 4;
    applyStimulus();
    id_rd = 4;
    @(negedge clk);
    checkOutput("waw_stall", int'(stall), 1);
    applyStimulus();
    id_is_mc = 1;
    @(negedge clk);
    checkOutput("mc2_stall", int'(stall), 1);
    applyStimulus();
    checkOutput("pre_rst_busy", int'(mc_busy), 1);
    rst_n = 0;
    #1;
    checkOutput("async_busy", int'(mc_busy), 0);
    checkOutput("async_rd", int'(mc_rd), 0);
    checkOutput("async_count", int'(stall_count), 0);
    applyStimulus();
    applyStimulus();
    rst_n = 1;
    for (int i = 0; i < 6; i++) begin
      applyStimulus();
      @(negedge clk);
      checkOutput("post_rst_done", int'(mc_done), 0);
    end

    // Saturation of the stall counter.
    for (int i = 0; i < CNT_MAX + 5; i++) begin
      applyStimulus();
      loadUseX7();
      @(negedge clk);
      if (i == 100) checkOutput("sat_mid", int'(stall_count), 100);
    end
    applyStimulus();
    @(negedge clk);
    checkOutput("sat_count", int'(stall_count), CNT_MAX);

    $display("[TB] %0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule
